clken_gen: RTL and testbench

- Parametrised successor to the fixed multi-output system PLL.
- Derives NUM_CH clock-enable strobes from one master clock using per-channel fractional phase-accumulator dividers.
- Divide ratios are programmable at run time and updated glitch-free; a sync input phase-aligns all channels.
- Sits directly after the PLL and feeds CPU, video and sound timing with exact-average enables such as 3.546895 MHz, without extra PLL outputs.

---
 rtl/clken_gen.sv | 190 +++++++++++++++++++
 tb/tb_clken_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator.
//
// Each channel runs an ACC_W-bit phase accumulator. Every refclk cycle the
// channel increment is added to the accumulator. The carry out of that add
// becomes a registered one-cycle enable strobe, so the average strobe rate is
// f_refclk * inc / 2^ACC_W. Software can change increments at run time. A new
// increment is first held as pending. It takes effect only on the channel's
// own wrap (carry) edge, so a strobe is never shortened or duplicated. A sync
// pulse restarts all accumulators together so that channels with equal
// increments stay in phase.
//
// Optional feature: define CLKEN_SQUARE_EN to add clk_sq, a per-channel
// square wave that toggles on every strobe (f_out / 2).
//
// Ports:
//   refclk  in   master clock; all state changes on the rising edge
//   rst     in   synchronous active-high reset, overrides everything
//   sync    in   one-cycle pulse: zero accumulators, restart lock count,
//                apply every pending increment
//   wr_en   in   increment write strobe
//   wr_ch   in   [3:0] target channel; values >= NUM_CH are ignored
//   wr_data in   [ACC_W-1:0] new increment
//   pend    out  [NUM_CH-1:0] channel holds an increment not yet applied
//   clken   out  [NUM_CH-1:0] one-cycle enable strobes
//   locked  out  strobes released after LOCK_CYCLES cycles
//   clk_sq  out  [NUM_CH-1:0] square outputs (CLKEN_SQUARE_EN only)

module clken_gen #(
    parameter int                          NUM_CH      = 8,
    parameter int                          ACC_W       = 24,
    parameter int                          LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0]     INC_RST     = '0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [ACC_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] clken,
`ifdef CLKEN_SQUARE_EN
    output logic [NUM_CH-1:0] clk_sq,
`endif
    output logic              locked
);

    // The lock counter must be able to hold LOCK_CYCLES itself, because it
    // saturates there.
    localparam int               CNT_W     = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [ACC_W-1:0]  acc_q      [NUM_CH];
    logic [ACC_W-1:0]  acc_d      [NUM_CH];
    logic [ACC_W-1:0]  inc_q      [NUM_CH];
    logic [ACC_W-1:0]  inc_d      [NUM_CH];
    logic [ACC_W-1:0]  pend_val_q [NUM_CH];
    logic [ACC_W-1:0]  pend_val_d [NUM_CH];
    logic [ACC_W:0]    sum_w      [NUM_CH];
    logic [NUM_CH-1:0] carry_w;
    logic [NUM_CH-1:0] pend_q,  pend_d;
    logic [NUM_CH-1:0] clken_q, clken_d;
    logic              locked_q, locked_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
`ifdef CLKEN_SQUARE_EN
    logic [NUM_CH-1:0] clk_sq_q, clk_sq_d;
`endif

    // Accumulator adders. The add is one bit wider than the accumulator, and
    // the extra top bit is the wrap carry that drives the strobe.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_w[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            carry_w[i] = sum_w[i][ACC_W];
        end
    end

    // Next-state logic for the accumulators, increments, pending slots,
    // strobes and lock tracking. Sync takes priority over normal running.
    // A write is handled last, so a write in the same cycle as an apply
    // (by carry or by sync) leaves the new value pending.
    always_comb begin
        pend_d   = pend_q;
        clken_d  = '0;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]      = acc_q[i];
            inc_d[i]      = inc_q[i];
            pend_val_d[i] = pend_val_q[i];
        end

        if (sync) begin
            locked_d = 1'b0;
            cnt_d    = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
                if (pend_q[i]) begin
                    inc_d[i]  = pend_val_q[i];
                    pend_d[i] = 1'b0;
                end
            end
        end else begin
            if (cnt_q != LOCK_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            locked_d = locked_q | (cnt_q == LOCK_LAST);
            for (int i = 0; i < NUM_CH; i++) begin
                // The accumulator still advances with the old increment on
                // the apply edge, so the wrap that triggered the apply is
                // kept intact.
                acc_d[i]   = sum_w[i][ACC_W-1:0];
                clken_d[i] = carry_w[i] & locked_q;
                // A stopped channel (inc == 0) would never carry, so it
                // takes a pending value on the next edge.
                if (pend_q[i] && (carry_w[i] || (inc_q[i] == '0))) begin
                    inc_d[i]  = pend_val_q[i];
                    pend_d[i] = 1'b0;
                end
            end
        end

        // Writes to channel indices that do not exist match no slot and are
        // dropped.
        if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch == 4'(i)) begin
                    pend_val_d[i] = wr_data;
                    pend_d[i]     = 1'b1;
                end
            end
        end
    end

`ifdef CLKEN_SQUARE_EN
    // The square output flips on the same edge that raises the strobe.
    // clken_d is already gated by locked, so the square output holds while
    // the generator is unlocked.
    always_comb begin
        if (sync) begin
            clk_sq_d = '0;
        end else begin
            clk_sq_d = clk_sq_q ^ clken_d;
        end
    end
`endif

    // State registers. Reset restores each channel's increment from its
    // slice of INC_RST and drops any pending write.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]      <= '0;
                inc_q[i]      <= INC_RST[i*ACC_W +: ACC_W];
                pend_val_q[i] <= '0;
            end
            pend_q   <= '0;
            clken_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clken_q    <= clken_d;
            locked_q   <= locked_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef CLKEN_SQUARE_EN
    // Square-wave toggle registers, cleared by reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            clk_sq_q <= '0;
        end else begin
            clk_sq_q <= clk_sq_d;
        end
    end

    assign clk_sq = clk_sq_q;
`endif

    assign pend   = pend_q;
    assign clken  = clken_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: scoreboard testbench for clken_gen with NUM_CH=2, ACC_W=8,
// LOCK_CYCLES=4, and a reset increment of 64 on channel 0.
// Each stimulus segment queues hand-derived expected {clken, pend, locked}
// values, each tagged with the cycle where it must appear. A separate
// monitor pops and compares those entries on the falling clock edge.

module tb_clken_gen;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 4;

    typedef struct {
        int         cyc;
        logic [1:0] clken;
        logic [1:0] pend;
        logic       locked;
        string      name;
    } exp_t;

    logic             refClk = 1'b0;
    logic             rst    = 1'b1;
    logic             syncIn = 1'b0;
    logic             wrEn   = 1'b0;
    logic [3:0]       wrCh   = 4'd0;
    logic [ACC_W-1:0] wrData = '0;
    logic [1:0]       pendOut;
    logic [1:0]       clkenOut;
    logic             lockedOut;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   segBase    = 0;
    int   checks     = 0;
    int   errors     = 0;

    clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .INC_RST     ({8'd0, 8'd64})
    ) dut (
        .refclk  (refClk),
        .rst     (rst),
        .sync    (syncIn),
        .wr_en   (wrEn),
        .wr_ch   (wrCh),
        .wr_data (wrData),
        .pend    (pendOut),
        .clken   (clkenOut),
        .locked  (lockedOut)
    );

    // Free-running 10-unit master clock.
    always #5 refClk = ~refClk;

    // Count rising edges so that expectations can target absolute cycles.
    always @(posedge refClk) begin
        cycleCount <= cycleCount + 1;
    end

    // Compare one queued expectation with the DUT outputs.
    task automatic checkOutput(input exp_t e);
        checks++;
        if ({clkenOut, pendOut, lockedOut} !== {e.clken, e.pend, e.locked}) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got clken=%b pend=%b locked=%b, expected clken=%b pend=%b locked=%b",
                     e.name, cycleCount, clkenOut, pendOut, lockedOut, e.clken, e.pend, e.locked);
        end
    endtask

    // The monitor runs on the falling edge, away from the edge where the DUT
    // updates. It reports stale entries as errors, then compares every entry
    // that belongs to the current cycle.
    always @(negedge refClk) begin
        while (expQ.size() > 0 && expQ[0].cyc < cycleCount) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d was skipped", expQ[0].name, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        while (expQ.size() > 0 && expQ[0].cyc == cycleCount) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Queue an expectation at an offset from the current segment base.
    task automatic expectAt(input int off, input logic [1:0] ck, input logic [1:0] pd,
                            input logic lk, input string nm);
        exp_t e;
        e.cyc    = segBase + off;
        e.clken  = ck;
        e.pend   = pd;
        e.locked = lk;
        e.name   = nm;
        expQ.push_back(e);
    endtask

    // Drive one cycle's inputs, let one rising edge sample them, and return
    // just after that edge.
    task automatic applyStimulus(input logic en, input logic [3:0] ch, input logic [ACC_W-1:0] data,
                                 input logic sy, input logic rs);
        wrEn   = en;
        wrCh   = ch;
        wrData = data;
        syncIn = sy;
        rst    = rs;
        @(posedge refClk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    endtask

    // Main stimulus sequence.
    initial begin
        $display("[TB] clken_gen scoreboard bench starting");

        // Reset, then run from the reset increment of 64: locked rises on the
        // 4th edge after release, and ch0 strobes every 4 cycles from offset 8.
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
        segBase = cycleCount;
        for (int off = 0; off <= 16; off++) begin
            logic b;
            b = (off >= 8) && (off % 4 == 0);
            expectAt(off, {1'b0, b}, 2'b00, off >= 4, "reset_lock_inc64");
        end
        idle(16);

        // Load 96 into ch0 and apply it with sync. The accumulator then runs
        // 96,192,32c,128,224,64c,160,0c, and strobes while locked.
        segBase = cycleCount;
        expectAt(1, 2'b00, 2'b01, 1'b1, "pend_set_ch0");
        expectAt(2, 2'b00, 2'b00, 1'b0, "sync_clear");
        for (int off = 3; off <= 18; off++) begin
            int   s;
            logic b;
            s = off - 2;
            b = (s == 6) || (s == 8) || (s == 11) || (s == 14) || (s == 16);
            expectAt(off, {1'b0, b}, 2'b00, s >= 4, "inc96_pattern");
        end
        applyStimulus(1'b1, 4'd0, 8'd96, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        idle(16);

        // Set inc 64 with sync. Two cycles after the strobe at t=8, write 32.
        // It stays pending until the carry at t=12, so spacing changes 4 -> 8.
        segBase = cycleCount;
        expectAt(1, 2'b00, 2'b01, 1'b1, "pend_set_ch0_64");
        expectAt(2, 2'b00, 2'b00, 1'b0, "sync_clear_64");
        for (int off = 3; off <= 30; off++) begin
            int   t;
            logic b;
            logic p;
            t = off - 2;
            b = (t == 8) || (t == 12) || (t == 20) || (t == 28);
            p = (t == 10) || (t == 11);
            expectAt(off, {1'b0, b}, {1'b0, p}, t >= 4, "glitchfree_apply");
        end
        applyStimulus(1'b1, 4'd0, 8'd64, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        idle(9);
        applyStimulus(1'b1, 4'd0, 8'd32, 1'b0, 1'b0);
        idle(18);

        // Write to channel 5, which does not exist: the write is ignored.
        // Then write 128 to idle ch1. It applies on the next edge, and from
        // offset 5 it strobes every 2 cycles. ch0 keeps its inc-32 spacing.
        segBase = cycleCount;
        for (int off = 1; off <= 16; off++) begin
            logic b0;
            logic b1;
            b0 = (off == 8) || (off == 16);
            b1 = (off >= 5) && (off % 2 == 1);
            expectAt(off, {b1, b0}, (off == 2) ? 2'b10 : 2'b00, 1'b1, "badch_and_idle_apply");
        end
        applyStimulus(1'b1, 4'd5, 8'd200, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 8'd128, 1'b0, 1'b0);
        idle(14);

        // Queue 96 on both channels while their phases differ, then sync.
        // After the sync both channels strobe on the same cycles.
        segBase = cycleCount;
        expectAt(1, 2'b10, 2'b01, 1'b1, "offset_phase_a");
        expectAt(2, 2'b00, 2'b11, 1'b1, "offset_phase_b");
        expectAt(3, 2'b00, 2'b00, 1'b0, "sync_aligned_clear");
        for (int off = 4; off <= 19; off++) begin
            int   s;
            logic b;
            s = off - 3;
            b = (s == 6) || (s == 8) || (s == 11) || (s == 14) || (s == 16);
            expectAt(off, {b, b}, 2'b00, s >= 4, "phase_aligned");
        end
        applyStimulus(1'b1, 4'd0, 8'd96, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 8'd96, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        idle(16);

        // Assert reset mid-stream while a write is pending, with sync also
        // high. Everything clears, and ch0 returns to the reset increment 64.
        segBase = cycleCount;
        expectAt(1, 2'b00, 2'b10, 1'b1, "pend_before_rst");
        expectAt(2, 2'b00, 2'b00, 1'b0, "midstream_rst");
        for (int off = 3; off <= 18; off++) begin
            int   r;
            logic b;
            r = off - 2;
            b = (r >= 8) && (r % 4 == 0);
            expectAt(off, {1'b0, b}, 2'b00, r >= 4, "post_rst_inc64");
        end
        applyStimulus(1'b1, 4'd1, 8'd50, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 1'b1);
        idle(16);

        // Let the monitor reach the last queued cycle, then report any
        // expectations that were never compared.
        idle(2);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
